usb_tx_encoder: RTL and testbench

- Transmit-side counterpart of the USB full-speed receive path.
- Accepts packet bytes over a valid/ready handshake and serializes them LSB first.
- Inserts a stuff bit after every six consecutive ones, NRZI-encodes the stream and drives the differential pair.
- Terminates each packet with EOP: SE0 for two bit times, then J for one bit time.

---
 rtl/usb_tx_pkg.sv | 19 +
 rtl/usb_tx_encoder_pts_sr.sv | 29 ++
 rtl/usb_tx_encoder.sv | 157 +++++++++++++++
 tb/tb_usb_tx_encoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared FSM states, protocol constants and line-state encodings for usb_tx_encoder
package usb_tx_pkg;
   typedef enum logic [2:0] {
      IDLE,
`ifdef USB_TX_SYNC_GEN_EN
      SYNC,
`endif
      SHIFT,
      STUFF,
      EOP1,
      EOP2,
      EOP_J
   } state_e;
   localparam logic [7:0] SYNC_BYTE   = 8'h80;
   localparam logic [2:0] STUFF_LIMIT = 3'd6;
   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;
endpackage

// File: rtl/usb_tx_encoder_pts_sr.sv
// flex_pts_sr: parallel-load, shift-on-enable shift register with serial output
//   clk, n_rst   : clock, synchronous active-low reset
//   shift_en     : shift one position toward the serial end
//   load_en      : parallel load from par_in (wins over shift_en)
//   par_in       : parallel load data
//   serial_out   : bit at the serial end (LSB when SHIFT_MSB=0)
module flex_pts_sr #(
   parameter int NUM_BITS  = 8,
   parameter bit SHIFT_MSB = 1'b0
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                shift_en,
   input  logic                load_en,
   input  logic [NUM_BITS-1:0] par_in,
   output logic                serial_out
);
   logic [NUM_BITS-1:0] sr_q, sr_d;
   always_comb begin
      sr_d = load_en  ? par_in :
             shift_en ? (SHIFT_MSB ? {sr_q[NUM_BITS-2:0], 1'b0} : {1'b0, sr_q[NUM_BITS-1:1]}) :
             sr_q;
   end
   always_ff @(posedge clk) begin
      if (!n_rst) sr_q <= '0;
      else        sr_q <= sr_d;
   end
   assign serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];
endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed transmit path (byte serializer, bit stuffing, NRZI, EOP)
//   clk, n_rst          : clock, synchronous active-low reset
//   tx_data/valid/last  : byte input handshake; tx_ready = holding register free
//   d_plus, d_minus     : differential line (J=10, K=01, SE0=00)
//   tx_busy             : packet in progress through the end of the EOP J bit
//   tx_done             : pulse on the last cycle of the EOP J bit
//   tx_err              : pulse on underrun
// Optional build macro USB_TX_SYNC_GEN_EN: prepend the SYNC pattern automatically.
import usb_tx_pkg::*;
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       d_plus,
   output logic       d_minus,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);
   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d, hold_q, hold_d, sr_in;
   logic [2:0] idx_q, idx_d, stuff_q, stuff_d;
   logic       hold_full_q, hold_full_d, hold_last_q, hold_last_d;
   logic       cur_last_q, cur_last_d, last_acc_q, last_acc_d;
   logic       level_q, level_d, err_q, err_d;
   logic       xfer, wrap, sr_load, sr_shift, sr_out, emit, bit_v;
   // The shifter holds only the bits not yet on the line: bit 0 of a byte is
   // emitted in the same edge the byte is loaded, so the load is pre-shifted.
   flex_pts_sr #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_sr (
      .clk(clk), .n_rst(n_rst), .shift_en(sr_shift), .load_en(sr_load),
      .par_in(sr_in), .serial_out(sr_out)
   );
   assign wrap     = cnt_q == 8'(CLKS_PER_BIT - 1);
   assign xfer     = tx_valid && tx_ready;
   assign tx_ready = !hold_full_q && !last_acc_q && !(state_q inside {EOP1, EOP2, EOP_J});
   assign tx_busy  = state_q != IDLE;
   assign tx_done  = state_q == EOP_J && wrap;
   assign tx_err   = err_q;
   assign {d_plus, d_minus} = (state_q == EOP1 || state_q == EOP2) ? SE0 : level_q ? J : K;
   always_comb begin
      state_d     = state_q;
      cnt_d       = (state_q == IDLE || wrap) ? 8'd0 : cnt_q + 8'd1;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      hold_last_d = hold_last_q;
      cur_last_d  = cur_last_q;
      last_acc_d  = last_acc_q || (xfer && tx_last);
      idx_d       = idx_q;
      stuff_d     = stuff_q;
      level_d     = level_q;
      err_d       = 1'b0;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      sr_in       = '0;
      emit        = 1'b0;
      bit_v       = 1'b0;
      if (xfer && state_q != IDLE) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
         hold_last_d = tx_last;
      end
      case (state_q)
         IDLE: if (xfer) begin
`ifdef USB_TX_SYNC_GEN_EN
            state_d     = SYNC;
            sr_in       = {1'b0, SYNC_BYTE[7:1]};
            bit_v       = SYNC_BYTE[0];
            hold_d      = tx_data;
            hold_full_d = 1'b1;
            hold_last_d = tx_last;
            cur_last_d  = 1'b0;
`else
            state_d     = SHIFT;
            sr_in       = {1'b0, tx_data[7:1]};
            bit_v       = tx_data[0];
            cur_last_d  = tx_last;
`endif
            sr_load     = 1'b1;
            emit        = 1'b1;
            idx_d       = '0;
         end
         EOP1: if (wrap) state_d = EOP2;
         EOP2: if (wrap) begin
            state_d = EOP_J;
            level_d = 1'b1;
         end
         EOP_J: if (wrap) begin
            state_d    = IDLE;
            last_acc_d = 1'b0;
         end
         default: if (wrap) begin
            // Stuffing has priority over the end-of-byte decision, so a run
            // completed by bit 7 defers the reload (or EOP) by one bit time.
            if (stuff_q == STUFF_LIMIT) begin
               state_d = STUFF;
               emit    = 1'b1;
            end else if (idx_q != 3'd7) begin
               state_d  = SHIFT;
               sr_shift = 1'b1;
               emit     = 1'b1;
               bit_v    = sr_out;
               idx_d    = idx_q + 3'd1;
            end else if (hold_full_q) begin
               state_d     = SHIFT;
               sr_load     = 1'b1;
               sr_in       = {1'b0, hold_q[7:1]};
               bit_v       = hold_q[0];
               emit        = 1'b1;
               idx_d       = '0;
               hold_full_d = xfer;
               cur_last_d  = hold_last_q;
            end else begin
               state_d    = EOP1;
               err_d      = !cur_last_q;
               cur_last_d = 1'b0;
               stuff_d    = '0;
            end
         end
      endcase
      if (emit) begin
         level_d = bit_v ? level_q : !level_q;
         stuff_d = bit_v ? (state_q == IDLE ? 3'd0 : stuff_q) + 3'd1 : 3'd0;
      end
   end
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         hold_last_q <= 1'b0;
         cur_last_q  <= 1'b0;
         last_acc_q  <= 1'b0;
         idx_q       <= '0;
         stuff_q     <= '0;
         level_q     <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         hold_last_q <= hold_last_d;
         cur_last_q  <= cur_last_d;
         last_acc_q  <= last_acc_d;
         idx_q       <= idx_d;
         stuff_q     <= stuff_d;
         level_q     <= level_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: directed self-checking bench for usb_tx_encoder (CLKS_PER_BIT=8)
module tb_usb_tx_encoder;
   localparam logic [1:0] J = 2'b10, K = 2'b01, Z = 2'b00;
   logic       clk = 1'b0, n_rst = 1'b0, tx_valid = 1'b0, tx_last = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_err;
   int         total = 0, bad = 0;
   logic [1:0] ln[$];
   logic       rd[$];
   int         done_at, n_done, err_at, n_err;
   bit         tmo;

   usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
      .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready), .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy),
      .tx_done(tx_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   task automatic feed(input logic [7:0] b0, input logic [7:0] b1, input int n, input logic last);
      logic [7:0] b[2];
      b[0] = b0;
      b[1] = b1;
      for (int i = 0; i < n; i++) begin
         int w = 0;
         @(negedge clk);
         while (!tx_ready && w < 400) begin
            @(negedge clk);
            w++;
         end
         total++;
         if (!tx_ready) begin
            bad++;
            $display("FAIL feed_ready byte %0d got 0 exp 1", i);
         end
         tx_data  = b[i];
         tx_last  = last && (i == n - 1);
         tx_valid = 1'b1;
         @(negedge clk);
         tx_valid = 1'b0;
         tx_last  = 1'b0;
      end
   endtask

   task automatic capture();
      int n = 0;
      ln.delete();
      rd.delete();
      done_at = -1; n_done = 0; err_at = -1; n_err = 0; tmo = 0;
      @(negedge clk);
      while (!tx_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!tx_busy) tmo = 1;
      n = 0;
      while (tx_busy && n < 1000) begin
         ln.push_back({d_plus, d_minus});
         rd.push_back(tx_ready);
         if (tx_done) begin n_done++; done_at = ln.size() - 1; end
         if (tx_err) begin n_err++; err_at = ln.size() - 1; end
         @(negedge clk);
         n++;
      end
      if (tx_busy) tmo = 1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      total++;
      if ({d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err} !== 6'b101000) begin
         bad++;
         $display("FAIL reset_vals got %b exp 101000", {d_plus, d_minus, tx_ready, tx_busy, tx_done, tx_err});
      end
   endtask

   task automatic test_stuff_ff();
      logic [1:0] e[12] = '{J, J, J, J, J, J, K, K, K, Z, Z, J};
      fork
         feed(8'hFF, 8'h00, 1, 1'b1);
         capture();
      join
      total++;
      if (tmo || ln.size() != 96) begin bad++; $display("FAIL ff_busy_len got %0d exp 96", ln.size()); end
      for (int k = 0; k < 12; k++) begin
         logic [1:0] got;
         got = e[k];
         for (int c = 0; c < 8; c++) if (8*k+c < ln.size() && got === e[k] && ln[8*k+c] !== e[k]) got = ln[8*k+c];
         total++;
         if (got !== e[k]) begin bad++; $display("FAIL ff_bit%0d got %b exp %b", k, got, e[k]); end
      end
      total++;
      if (n_done != 1 || done_at != 95) begin bad++; $display("FAIL ff_done got n=%0d at=%0d exp n=1 at=95", n_done, done_at); end
      total++;
      if (ln.size() > 16 && rd[16] !== 1'b0) begin bad++; $display("FAIL ff_refuse_after_last got %b exp 0", rd[16]); end
      total++;
      if (n_err != 0) begin bad++; $display("FAIL ff_no_err got %0d exp 0", n_err); end
      total++;
      if ({tx_ready, tx_busy, d_plus, d_minus} !== 4'b1010) begin bad++; $display("FAIL ff_idle got %b exp 1010", {tx_ready, tx_busy, d_plus, d_minus}); end
   endtask

   task automatic test_zeros();
      logic [1:0] e[11] = '{K, J, K, J, K, J, K, J, Z, Z, J};
      fork
         feed(8'h00, 8'h00, 1, 1'b1);
         capture();
      join
      total++;
      if (tmo || ln.size() != 88) begin bad++; $display("FAIL zero_busy_len got %0d exp 88", ln.size()); end
      for (int k = 0; k < 11; k++) begin
         logic [1:0] got;
         got = e[k];
         for (int c = 0; c < 8; c++) if (8*k+c < ln.size() && got === e[k] && ln[8*k+c] !== e[k]) got = ln[8*k+c];
         total++;
         if (got !== e[k]) begin bad++; $display("FAIL zero_bit%0d got %b exp %b", k, got, e[k]); end
      end
      total++;
      if (n_done != 1 || done_at != 87) begin bad++; $display("FAIL zero_done got n=%0d at=%0d exp n=1 at=87", n_done, done_at); end
   endtask

   task automatic test_span();
      logic [1:0] e[20] = '{K, J, K, J, J, J, J, J, J, J, K, J, K, J, K, J, K, Z, Z, J};
      fork
         feed(8'hF0, 8'h03, 2, 1'b1);
         capture();
      join
      total++;
      if (tmo || ln.size() != 160) begin bad++; $display("FAIL span_busy_len got %0d exp 160", ln.size()); end
      for (int k = 0; k < 20; k++) begin
         logic [1:0] got;
         got = e[k];
         for (int c = 0; c < 8; c++) if (8*k+c < ln.size() && got === e[k] && ln[8*k+c] !== e[k]) got = ln[8*k+c];
         total++;
         if (got !== e[k]) begin bad++; $display("FAIL span_bit%0d got %b exp %b", k, got, e[k]); end
      end
      total++;
      if (n_done != 1 || n_err != 0) begin bad++; $display("FAIL span_flags got done=%0d err=%0d exp done=1 err=0", n_done, n_err); end
   endtask

   task automatic test_stuff_at_end();
      logic [1:0] e[20] = '{K, J, J, J, J, J, J, J, K, J, K, J, K, J, K, J, J, Z, Z, J};
      fork
         feed(8'hFC, 8'h80, 2, 1'b1);
         capture();
      join
      total++;
      if (tmo || ln.size() != 160) begin bad++; $display("FAIL end_busy_len got %0d exp 160", ln.size()); end
      for (int k = 0; k < 20; k++) begin
         logic [1:0] got;
         got = e[k];
         for (int c = 0; c < 8; c++) if (8*k+c < ln.size() && got === e[k] && ln[8*k+c] !== e[k]) got = ln[8*k+c];
         total++;
         if (got !== e[k]) begin bad++; $display("FAIL end_bit%0d got %b exp %b", k, got, e[k]); end
      end
      total++;
      if (n_done != 1 || done_at != 159) begin bad++; $display("FAIL end_done got n=%0d at=%0d exp n=1 at=159", n_done, done_at); end
   endtask

   task automatic test_underrun();
      logic [1:0] e[11] = '{J, K, K, J, J, K, K, J, Z, Z, J};
      fork
         feed(8'h55, 8'h00, 1, 1'b0);
         capture();
      join
      total++;
      if (tmo || ln.size() != 88) begin bad++; $display("FAIL urun_busy_len got %0d exp 88", ln.size()); end
      for (int k = 0; k < 11; k++) begin
         logic [1:0] got;
         got = e[k];
         for (int c = 0; c < 8; c++) if (8*k+c < ln.size() && got === e[k] && ln[8*k+c] !== e[k]) got = ln[8*k+c];
         total++;
         if (got !== e[k]) begin bad++; $display("FAIL urun_bit%0d got %b exp %b", k, got, e[k]); end
      end
      total++;
      if (n_err != 1 || err_at != 64) begin bad++; $display("FAIL urun_err got n=%0d at=%0d exp n=1 at=64", n_err, err_at); end
      total++;
      if ({tx_ready, tx_busy} !== 2'b10) begin bad++; $display("FAIL urun_idle got %b exp 10", {tx_ready, tx_busy}); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] e[11] = '{J, K, K, J, K, K, J, J, Z, Z, J};
      int dn = 0, bz = 0;
      feed(8'hA5, 8'h00, 1, 1'b1);
      repeat (27) @(negedge clk);
      total++;
      if ({tx_busy, d_plus, d_minus} !== 3'b110) begin bad++; $display("FAIL rmid_pre got %b exp 110", {tx_busy, d_plus, d_minus}); end
      n_rst = 1'b0;
      @(negedge clk);
      total++;
      if ({d_plus, d_minus, tx_busy, tx_ready, tx_done} !== 5'b10010) begin
         bad++;
         $display("FAIL rmid_after got %b exp 10010", {d_plus, d_minus, tx_busy, tx_ready, tx_done});
      end
      n_rst = 1'b1;
      repeat (120) begin
         @(negedge clk);
         if (tx_done) dn++;
         if (tx_busy || {d_plus, d_minus} !== J) bz++;
      end
      total++;
      if (dn != 0 || bz != 0) begin bad++; $display("FAIL rmid_quiet got done=%0d active=%0d exp 0 0", dn, bz); end
      fork
         feed(8'hA5, 8'h00, 1, 1'b1);
         capture();
      join
      total++;
      if (tmo || ln.size() != 88) begin bad++; $display("FAIL rmid_busy_len got %0d exp 88", ln.size()); end
      for (int k = 0; k < 11; k++) begin
         logic [1:0] got;
         got = e[k];
         for (int c = 0; c < 8; c++) if (8*k+c < ln.size() && got === e[k] && ln[8*k+c] !== e[k]) got = ln[8*k+c];
         total++;
         if (got !== e[k]) begin bad++; $display("FAIL rmid_bit%0d got %b exp %b", k, got, e[k]); end
      end
   endtask

   initial begin
      test_reset();
      test_stuff_ff();
      test_zeros();
      test_span();
      test_stuff_at_end();
      test_underrun();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
